decode_writeback: RTL

Combined decode/write-back stage of the sequential Y86-64 processor, directly downstream of instruction fetch. Holds the 15-entry × 64-bit architectural register file. From fetched icode/rA/rB it selects source and destination registers, supplies valA/valB to execute combinationally, and commits valE/valM on the clock edge that retires the instruction.

---
 rtl/decode_writeback_if.sv | 37 +++
 rtl/decode_writeback.sv | 115 +++++++++++
 2 files changed

// File: rtl/decode_writeback_if.sv
// ---------------------------------------------------------------------------
// decode_writeback_if
// Bundles the signals between the decode/write-back stage and its neighbours
// in the sequential Y86-64 datapath.
//   From fetch   : icode, rA, rB
//   From execute : Cnd, valE
//   From memory  : valM
//   Control      : wb_en (instruction retires this cycle)
//   To execute   : srcA, srcB, dstE, dstM, valA, valB
// The master modport is the surrounding datapath; the slave modport is the
// decode/write-back stage itself.
// ---------------------------------------------------------------------------
interface decode_writeback_if;
  logic [3:0]  icode;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic        Cnd;
  logic [63:0] valE;
  logic [63:0] valM;
  logic        wb_en;
  logic [3:0]  srcA;
  logic [3:0]  srcB;
  logic [3:0]  dstE;
  logic [3:0]  dstM;
  logic [63:0] valA;
  logic [63:0] valB;

  modport master (
    output icode, rA, rB, Cnd, valE, valM, wb_en,
    input  srcA, srcB, dstE, dstM, valA, valB
  );

  modport slave (
    input  icode, rA, rB, Cnd, valE, valM, wb_en,
    output srcA, srcB, dstE, dstM, valA, valB
  );
endinterface

// File: rtl/decode_writeback.sv
// ---------------------------------------------------------------------------
// decode_writeback
// Combined decode and write-back stage of the sequential Y86-64 processor.
// Holds the 15 x 64-bit architectural register file (%rax..%r14).
//   clk  : sole clock, register writes on the rising edge
//   rst  : asynchronous active-high reset, clears every register
//   bus  : decode_writeback_if.slave
//          inputs  icode/rA/rB/Cnd/valE/valM/wb_en
//          outputs srcA/srcB/dstE/dstM (register IDs, 0xF = none)
//                  valA/valB (combinational reads, 0 for ID 0xF)
// ---------------------------------------------------------------------------
module decode_writeback (
  input  logic                   clk,
  input  logic                   rst,
  decode_writeback_if.slave      bus
);

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  logic [63:0] r_regs [0:14];

  logic [3:0] w_srcA;
  logic [3:0] w_srcB;
  logic [3:0] w_dstE;
  logic [3:0] w_dstM;

  // Register ID selection. Any icode not listed (halt, nop, jXX, undefined)
  // leaves every ID at 0xF, which also suppresses reads and writes.
  always_comb begin
    w_srcA = RNONE;
    w_srcB = RNONE;
    w_dstE = RNONE;
    w_dstM = RNONE;
    case (bus.icode)
      I_CMOVXX: begin
        w_srcA = bus.rA;
        w_dstE = bus.Cnd ? bus.rB : RNONE;
      end
      I_IRMOVQ: w_dstE = bus.rB;
      I_RMMOVQ: begin
        w_srcA = bus.rA;
        w_srcB = bus.rB;
      end
      I_MRMOVQ: begin
        w_srcB = bus.rB;
        w_dstM = bus.rA;
      end
      I_OPQ: begin
        w_srcA = bus.rA;
        w_srcB = bus.rB;
        w_dstE = bus.rB;
      end
      I_CALL: begin
        w_srcB = RRSP;
        w_dstE = RRSP;
      end
      I_RET: begin
        w_srcA = RRSP;
        w_srcB = RRSP;
        w_dstE = RRSP;
      end
      I_PUSHQ: begin
        w_srcA = bus.rA;
        w_srcB = RRSP;
        w_dstE = RRSP;
      end
      I_POPQ: begin
        w_srcA = RRSP;
        w_srcB = RRSP;
        w_dstE = RRSP;
        w_dstM = bus.rA;
      end
      default: ;
    endcase
  end

  assign bus.srcA = w_srcA;
  assign bus.srcB = w_srcB;
  assign bus.dstE = w_dstE;
  assign bus.dstM = w_dstM;

  // Reads come straight from the current register contents with no bypass,
  // so an instruction reading its own destination sees the pre-edge value.
  assign bus.valA = (w_srcA == RNONE) ? 64'd0 : r_regs[w_srcA];
  assign bus.valB = (w_srcB == RNONE) ? 64'd0 : r_regs[w_srcB];

  // Write-back. The M port is written after the E port so that popq %rsp
  // leaves the popped value rather than the incremented stack pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) begin
        r_regs[i] <= 64'd0;
      end
    end else if (bus.wb_en) begin
      if (w_dstE != RNONE) begin
        r_regs[w_dstE] <= bus.valE;
      end
      if (w_dstM != RNONE) begin
        r_regs[w_dstM] <= bus.valM;
      end
    end
  end

endmodule
